// File: rtl/rvvi_rx_frame_filter.sv
`default_nettype none
// ============================================================================
//  Module   : rvvi_rx_frame_filter
//  Purpose  : Ethernet RX header filter for the RVVI host-feedback path.
//             Frames are staged in a small FIFO and forwarded only when the
//             header matches the programmed MACs and EtherType.
//  Revision : 1.0  initial release
// ============================================================================
module rvvi_rx_frame_filter #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [47:0]          LocalMac,
    input  logic [47:0]          HostMac,
    input  logic [15:0]          EthType,
    input  logic [31:0]          SAxiTdata,
    input  logic [3:0]           SAxiTkeep,
    input  logic                 SAxiTvalid,
    input  logic                 SAxiTlast,
    input  logic                 SAxiTuser,
    output logic [31:0]          MAxiTdata,
    output logic [3:0]           MAxiTkeep,
    output logic                 MAxiTvalid,
    output logic                 MAxiTlast,
    output logic                 MAxiTuser,
    output logic [CNT_WIDTH-1:0] PassCount,
    output logic [CNT_WIDTH-1:0] DropCount,
    output logic                 Overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 38;

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [PW-1:0]        c_ptrOne = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cntMax = {CNT_WIDTH{1'b1}};

    logic [1:0]           r_state, w_nextState;
    logic [1:0]           r_beatIdx, w_nextBeatIdx;
    logic                 r_match, w_nextMatch;
    logic [31:0]          w_expData;
    logic                 w_beatOk, w_matchAcc;
    logic                 w_wrEn, w_commit, w_rollback, w_passInc, w_dropInc;
    logic [PW-1:0]        r_wp, r_cp, r_rp, w_wpAfter;
    logic                 w_full, w_doWrite;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [31:0]          r_mData;
    logic [3:0]           r_mKeep;
    logic                 r_mValid, r_mLast, r_mUser;
    logic [CNT_WIDTH-1:0] r_passCount, r_dropCount;
    logic                 r_overflow;

    // Wire byte n sits in lane n, so the big-endian fields appear byte-swapped per beat.
    always_comb begin
        w_expData = '0;
        w_beatOk  = 1'b0;
        case (r_beatIdx)
            2'd0:    w_expData = {LocalMac[23:16], LocalMac[31:24], LocalMac[39:32], LocalMac[47:40]};
            2'd1:    w_expData = {HostMac[39:32], HostMac[47:40], LocalMac[7:0], LocalMac[15:8]};
            2'd2:    w_expData = {HostMac[7:0], HostMac[15:8], HostMac[23:16], HostMac[31:24]};
            default: w_expData = {16'h0000, EthType[7:0], EthType[15:8]};
        endcase
        if (r_beatIdx == 2'd3)
            w_beatOk = (SAxiTdata[15:0] == w_expData[15:0]) && (SAxiTkeep[1:0] == 2'b11);
        else
            w_beatOk = (SAxiTdata == w_expData) && (SAxiTkeep == 4'hF);
    end

    assign w_matchAcc = r_match & w_beatOk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_HDR;
            r_beatIdx <= 2'd0;
            r_match   <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_beatIdx <= w_nextBeatIdx;
            r_match   <= w_nextMatch;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextBeatIdx = r_beatIdx;
        w_nextMatch   = r_match;
        if (SAxiTvalid) begin
            case (r_state)
                S_HDR: begin
                    if (r_beatIdx != 2'd3) begin
                        if (SAxiTlast) begin
                            w_nextBeatIdx = 2'd0;
                            w_nextMatch   = 1'b1;
                        end else begin
                            w_nextBeatIdx = r_beatIdx + 2'd1;
                            w_nextMatch   = w_matchAcc;
                        end
                    end else begin
                        w_nextBeatIdx = 2'd0;
                        w_nextMatch   = 1'b1;
                        if (!SAxiTlast)
                            w_nextState = w_matchAcc ? S_PASS : S_DROP;
                    end
                end
                S_PASS, S_DROP: begin
                    if (SAxiTlast)
                        w_nextState = S_HDR;
                end
                default: w_nextState = S_HDR;
            endcase
        end
    end

    always_comb begin
        w_wrEn     = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        w_passInc  = 1'b0;
        w_dropInc  = 1'b0;
        if (SAxiTvalid) begin
            case (r_state)
                S_HDR: begin
                    w_wrEn = 1'b1;
                    if (r_beatIdx != 2'd3) begin
                        w_rollback = SAxiTlast;
                        w_dropInc  = SAxiTlast;
                    end else if (w_matchAcc) begin
                        w_commit  = 1'b1;
                        w_passInc = SAxiTlast;
                    end else begin
                        w_rollback = 1'b1;
                        w_dropInc  = SAxiTlast;
                    end
                end
                S_PASS: begin
                    w_wrEn    = 1'b1;
                    w_commit  = 1'b1;
                    w_passInc = SAxiTlast;
                end
                S_DROP: w_dropInc = SAxiTlast;
                default: ;
            endcase
        end
    end

    // Occupancy is measured against rp, so speculative header beats also count.
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_doWrite = w_wrEn & ~w_full;
    assign w_wpAfter = r_wp + {{AW{1'b0}}, w_doWrite};

    always_ff @(posedge clk) begin
        if (w_doWrite)
            r_mem[r_wp[AW-1:0]] <= {SAxiTuser, SAxiTlast, SAxiTkeep, SAxiTdata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp        <= '0;
            r_cp        <= '0;
            r_rp        <= '0;
            r_mData     <= '0;
            r_mKeep     <= '0;
            r_mValid    <= 1'b0;
            r_mLast     <= 1'b0;
            r_mUser     <= 1'b0;
            r_passCount <= '0;
            r_dropCount <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wp <= w_rollback ? r_cp : w_wpAfter;
            if (w_commit)
                r_cp <= w_wpAfter;
            if (r_rp != r_cp) begin
                {r_mUser, r_mLast, r_mKeep, r_mData} <= r_mem[r_rp[AW-1:0]];
                r_mValid <= 1'b1;
                r_rp     <= r_rp + c_ptrOne;
            end else begin
                r_mValid <= 1'b0;
            end
            if (w_passInc && (r_passCount != c_cntMax))
                r_passCount <= r_passCount + c_cntOne;
            if (w_dropInc && (r_dropCount != c_cntMax))
                r_dropCount <= r_dropCount + c_cntOne;
            if (w_wrEn && w_full)
                r_overflow <= 1'b1;
        end
    end

    assign MAxiTdata  = r_mData;
    assign MAxiTkeep  = r_mKeep;
    assign MAxiTvalid = r_mValid;
    assign MAxiTlast  = r_mLast;
    assign MAxiTuser  = r_mUser;
    assign PassCount  = r_passCount;
    assign DropCount  = r_dropCount;
    assign Overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/rvvi_rx_frame_filter.md
Name: rvvi_rx_frame_filter

Overview:
- Sits between the Ethernet MAC receive AXI-stream (32-bit, always-ready) and the host-feedback inverse packetizer in the RVVI hardware tracer.
- Checks each frame's Ethernet header (destination MAC, source MAC, EthType) against programmed values.
- Forwards matching frames unchanged, including the header.
- Silently discards non-matching, runt or malformed frames, so stray LAN traffic cannot corrupt host instruction-count or inter-packet-delay feedback.
- Keeps saturating pass/drop statistics.

Parameters:
FIFO_DEPTH, 8, entries in the internal beat FIFO; power of two, ≥8.
CNT_WIDTH, 16, width of the pass and drop counters.

Ports:
clk  input  1  core clock (single clock domain)
reset  input  1  asynchronous, active-high reset
LocalMac  input  48  expected destination MAC; held static
HostMac  input  48  expected source MAC; held static
EthType  input  16  expected EtherType; held static
SAxiTdata  input  32  receive data; byte n of the beat is on bits [8n+7:8n], and the lowest lane is the earliest wire byte
SAxiTkeep  input  4  byte enables
SAxiTvalid  input  1  beat valid; always accepted (no ready)
SAxiTlast  input  1  last beat of frame
SAxiTuser  input  1  MAC bad-frame flag; meaningful on the last beat
MAxiTdata  output  32  forwarded data
MAxiTkeep  output  4  forwarded keep
MAxiTvalid  output  1  forwarded valid (no ready; downstream always accepts)
MAxiTlast  output  1  forwarded last
MAxiTuser  output  1  forwarded bad-frame flag
PassCount  output  CNT_WIDTH  frames forwarded, saturating
DropCount  output  CNT_WIDTH  frames discarded, saturating
Overflow  output  1  sticky: a FIFO write was attempted while full

Behaviour:
- Reset (async): all outputs 0; FIFO empty; state HDR with beat index 0.
- Header layout: beat0 holds bytes 0-3, beat1 bytes 4-7, beat2 bytes 8-11, beat3 bytes 12-15.
  - Destination MAC byte 0 = LocalMac[47:40] (big-endian on the wire).
  - Source MAC occupies bytes 6-11.
  - EthType byte 12 = EthType[15:8], byte 13 = EthType[7:0].
  - Bytes 14-15 are payload and are not checked.
- FIFO pointers: write pointer wp, commit pointer cp, read pointer rp.
  - Every accepted beat is written at wp, and wp increments.
  - The output reads only entries in [rp, cp).
- State HDR, beat index k = 0..3:
  - Each beat is written speculatively and its fields are compared.
  - A running match flag is ANDed per beat.
  - Beats 0-2 require Tkeep = 4'hF; beat 3 requires Tkeep[1:0] = 2'b11. A violation counts as a mismatch.
  - Tlast on k < 3: runt. Roll back wp to cp, DropCount +1, stay in HDR, k = 0.
  - Beat 3 with match and no Tlast: cp = wp + 1 (commit), go to PASS.
  - Beat 3 with match and Tlast: commit, PassCount +1, stay in HDR.
  - Beat 3 with mismatch and no Tlast: roll back, go to DROP.
  - Beat 3 with mismatch and Tlast: roll back, DropCount +1, stay in HDR.
- State PASS:
  - Each beat is written and committed in the same cycle.
  - On Tlast: PassCount +1, go to HDR.
- State DROP:
  - Beats are ignored; no writes.
  - On Tlast: DropCount +1, go to HDR.
- Output: if rp ≠ cp, drive the entry at rp registered onto MAxi*, MAxiTvalid = 1, rp++; otherwise MAxiTvalid = 0.
  - Data, keep, last and user are bit-exact with the input.
  - Latency: beat3 accepted at edge N gives beat0 on MAxi* after edge N+1. Beats then leave at 1/cycle with no gaps while the FIFO is non-empty.
- The SAxiTuser flag does not affect the pass/drop decision. It is forwarded, and the downstream stage discards the frame.
- Rollback and commit use the pointer value after the current write, including when a write happens in the same cycle as a read.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by comparing MSBs.
  - A write while full sets Overflow and discards the beat.
  - With depth ≥8 and 1 beat/cycle in and out, a write while full is unreachable; Overflow exists only as a diagnostic.
- Counters saturate at all-ones.
- Reset deasserted mid-frame: the remainder of that frame is parsed as a header and normally dropped. No special state.
- Field inputs must be stable while a frame is in HDR; changes between frames take effect on the next frame.

Test Plan:
1. Matching 6-beat frame (LocalMac 48'h8F5400001654, HostMac 48'h450211116843, EthType 16'h005c), back-to-back beats → 6 identical output beats, first output two edges after beat3, MAxiTlast on beat 6, PassCount = 1.
2. Same frame with destination byte 5 altered → no MAxiTvalid at any point, DropCount = 1. A following matching frame passes intact.
3. Runt: 3 beats, Tlast on beat 2 → nothing output, DropCount = 1, state back to HDR. The next frame's beat0 is treated as header beat 0.
4. Matching frame with a 1-cycle valid gap every other beat, followed immediately by a mismatching frame → only the first frame is output, data identical and in order, PassCount = 1, DropCount = 1, Overflow = 0.
5. Matching frame whose last beat has SAxiTuser = 1 and Tkeep = 4'h3 → forwarded with MAxiTuser = 1 and MAxiTkeep = 4'h3 on the last beat, PassCount +1.
6. Assert reset during PASS after 3 payload beats → all outputs 0 immediately, FIFO empty. The remaining beats after release are dropped (DropCount = 1), and the next good frame passes.
